recursion_stack: RTL and testbench

//  LIFO frame store serving the recursive-function controllers; it is the responder to the controller's push/pop/top commands.

---
 rtl/recursion_stack_pkg.sv | 52 +++++
 rtl/recursion_stack_ram.sv | 26 ++
 rtl/recursion_stack.sv | 118 +++++++++++
 tb/tb_recursion_stack.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/recursion_stack_pkg.sv
// Shared definitions for the recursion frame stack and the controllers that
// use it: default geometry, frame bit-field layout and the command decode.
package recursion_stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;

    // Frame layout: bit 7 flags that the second recursive call is pending,
    // bits 6:0 carry the argument of this recursion level.
    localparam int FRAME_SECOND_BIT = 7;
    localparam int FRAME_ARG_MSB    = 6;
    localparam int FRAME_ARG_LSB    = 0;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_PUSH,
        CMD_POP,
        CMD_REPLACE,
        CMD_PEEK
    } stack_cmd_e;

    // Resolve one command group to the operation the stack performs.
    // push+pop on an empty stack degenerates to a plain push; top is
    // ignored whenever push or pop is also present.
    function automatic stack_cmd_e decode_cmd(input logic push,
                                              input logic pop,
                                              input logic top,
                                              input logic empty);
        stack_cmd_e cmd;
        cmd = CMD_NONE;
        if (push && pop)
            cmd = empty ? CMD_PUSH : CMD_REPLACE;
        else if (push)
            cmd = CMD_PUSH;
        else if (pop)
            cmd = CMD_POP;
        else if (top)
            cmd = CMD_PEEK;
        return cmd;
    endfunction

    // Pack a frame the way the controllers' datapath does.
    function automatic logic [STACK_WIDTH-1:0] pack_frame(input logic       second,
                                                          input logic [6:0] arg);
        logic [STACK_WIDTH-1:0] f;
        f = '0;
        f[FRAME_SECOND_BIT] = second;
        f[FRAME_ARG_MSB:FRAME_ARG_LSB] = arg;
        return f;
    endfunction

endpackage

// File: rtl/recursion_stack_ram.sv
// Frame storage: synchronous write, asynchronous read so the top frame is
// available to the controller in the same cycle it is addressed.
module recursion_stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/recursion_stack.sv
// LIFO frame store for the recursive-function controllers. Holds the stack
// pointer, command decode, sticky error flags and the occupancy high-water mark.
module recursion_stack
    import recursion_stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             top_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             isEmpty_o,
    output logic             full_o,
    output logic [AW:0]      level_o,
    output logic [AW:0]      maxLevel_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

    logic [AW:0]      sp_q, sp_d;
    logic [AW:0]      max_level_q, max_level_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             empty;
    logic             full;
    logic [AW-1:0]    top_addr;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] rdata;
    stack_cmd_e       cmd;

    assign empty    = (sp_q == '0);
    assign full     = (sp_q == SP_FULL);
    assign top_addr = sp_q[AW-1:0] - AW'(1);

    recursion_stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (din_i),
        .raddr_i (top_addr),
        .rdata_o (rdata)
    );

    // Command resolution: next stack pointer, write strobe and flag updates.
    always_comb begin
        cmd         = decode_cmd(push_i, pop_i, top_i, empty);
        sp_d        = sp_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        we          = 1'b0;
        waddr       = sp_q[AW-1:0];

        unique case (cmd)
            CMD_PUSH: begin
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    we   = 1'b1;
                    sp_d = sp_q + 1'b1;
                end
            end
            CMD_POP: begin
                if (empty)
                    underflow_d = 1'b1;
                else
                    sp_d = sp_q - 1'b1;
            end
            CMD_REPLACE: begin
                we    = 1'b1;
                waddr = top_addr;
            end
            CMD_PEEK: begin
                if (empty)
                    underflow_d = 1'b1;
            end
            default: ;
        endcase

        max_level_d = (sp_d > max_level_q) ? sp_d : max_level_q;
    end

    // Pointer, high-water mark and sticky flags; reset discards all frames.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q        <= '0;
            max_level_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            max_level_q <= max_level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign dout_o      = empty ? '0 : rdata;
    assign isEmpty_o   = empty;
    assign full_o      = full;
    assign level_o     = sp_q;
    assign maxLevel_o  = max_level_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_recursion_stack.sv
// Directed bench for recursion_stack with hand-computed expectations.
module tb_recursion_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             push_i = 1'b0;
    logic             pop_i = 1'b0;
    logic             top_i = 1'b0;
    logic [WIDTH-1:0] din_i = '0;
    logic [WIDTH-1:0] dout_o;
    logic             isEmpty_o;
    logic             full_o;
    logic [AW:0]      level_o;
    logic [AW:0]      maxLevel_o;
    logic             overflow_o;
    logic             underflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    recursion_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .top_i       (top_i),
        .din_i       (din_i),
        .dout_o      (dout_o),
        .isEmpty_o   (isEmpty_o),
        .full_o      (full_o),
        .level_o     (level_o),
        .maxLevel_o  (maxLevel_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        push_i = 1'b0;
        pop_i  = 1'b0;
        top_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        n_checks++; if (isEmpty_o !== 1'b1) begin n_fail++; $display("FAIL reset_isEmpty got %b want 1", isEmpty_o); end
        n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full_o); end
        n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level_o); end
        n_checks++; if (dout_o !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", dout_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow_o); end
        n_checks++; if (underflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %b want 0", underflow_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_push_pop();
        logic [7:0] pushed [3];
        logic [7:0] popped [3];
        pushed[0] = 8'h05; pushed[1] = 8'h03; pushed[2] = 8'h01;
        popped[0] = 8'h01; popped[1] = 8'h03; popped[2] = 8'h05;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_i = 1'b1;
            din_i  = pushed[i];
            tick();
        end
        push_i = 1'b0;
        n_checks++; if (level_o !== 5'd3) begin n_fail++; $display("FAIL pp_level3 got %0d want 3", level_o); end
        for (int i = 0; i < 3; i++) begin
            pop_i = 1'b1;
            #1;
            n_checks++; if (dout_o !== popped[i]) begin n_fail++; $display("FAIL pp_pop%0d_dout got %h want %h", i, dout_o, popped[i]); end
            tick();
        end
        pop_i = 1'b0;
        n_checks++; if (isEmpty_o !== 1'b1) begin n_fail++; $display("FAIL pp_isEmpty got %b want 1", isEmpty_o); end
        n_checks++; if (maxLevel_o !== 5'd3) begin n_fail++; $display("FAIL pp_maxLevel got %0d want 3", maxLevel_o); end
        n_checks++; if (dout_o !== 8'h00) begin n_fail++; $display("FAIL pp_dout_empty got %h want 00", dout_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push_i = 1'b1;
            din_i  = 8'h10 + 8'(i);
            tick();
            if (i == 14) begin
                n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL ov_full_at15 got %b want 0", full_o); end
            end
        end
        n_checks++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL ov_full got %b want 1", full_o); end
        n_checks++; if (level_o !== 5'd16) begin n_fail++; $display("FAIL ov_level16 got %0d want 16", level_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ov_early got %b want 0", overflow_o); end
        din_i = 8'hAA;
        tick();
        push_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ov_flag got %b want 1", overflow_o); end
        n_checks++; if (level_o !== 5'd16) begin n_fail++; $display("FAIL ov_level_held got %0d want 16", level_o); end
        n_checks++; if (dout_o !== 8'h1F) begin n_fail++; $display("FAIL ov_dout got %h want 1f", dout_o); end
        n_checks++; if (isEmpty_o !== 1'b0) begin n_fail++; $display("FAIL ov_isEmpty got %b want 0", isEmpty_o); end
        n_checks++; if (maxLevel_o !== 5'd16) begin n_fail++; $display("FAIL ov_maxLevel got %0d want 16", maxLevel_o); end
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        n_checks++; if (dout_o !== 8'h1E) begin n_fail++; $display("FAIL ov_after_pop_dout got %h want 1e", dout_o); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ov_sticky got %b want 1", overflow_o); end
    endtask

    task automatic test_underflow();
        do_reset();
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        n_checks++; if (underflow_o !== 1'b1) begin n_fail++; $display("FAIL un_pop_flag got %b want 1", underflow_o); end
        n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL un_pop_level got %0d want 0", level_o); end
        do_reset();
        top_i = 1'b1;
        tick();
        top_i = 1'b0;
        n_checks++; if (underflow_o !== 1'b1) begin n_fail++; $display("FAIL un_top_flag got %b want 1", underflow_o); end
        n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL un_top_level got %0d want 0", level_o); end
        n_checks++; if (dout_o !== 8'h00) begin n_fail++; $display("FAIL un_dout got %h want 00", dout_o); end
        push_i = 1'b1;
        din_i  = 8'h42;
        tick();
        din_i  = 8'h43;
        tick();
        push_i = 1'b0;
        n_checks++; if (underflow_o !== 1'b1) begin n_fail++; $display("FAIL un_sticky got %b want 1", underflow_o); end
        n_checks++; if (level_o !== 5'd2) begin n_fail++; $display("FAIL un_push_level got %0d want 2", level_o); end
        n_checks++; if (dout_o !== 8'h43) begin n_fail++; $display("FAIL un_push_dout got %h want 43", dout_o); end
    endtask

    task automatic test_replace();
        do_reset();
        push_i = 1'b1;
        pop_i  = 1'b1;
        din_i  = 8'hA0;
        tick();
        pop_i  = 1'b0;
        n_checks++; if (level_o !== 5'd1) begin n_fail++; $display("FAIL rp_empty_level got %0d want 1", level_o); end
        n_checks++; if (underflow_o !== 1'b0) begin n_fail++; $display("FAIL rp_empty_underflow got %b want 0", underflow_o); end
        n_checks++; if (dout_o !== 8'hA0) begin n_fail++; $display("FAIL rp_empty_dout got %h want a0", dout_o); end
        din_i = 8'hB0;
        tick();
        push_i = 1'b0;
        top_i  = 1'b1;
        tick();
        top_i  = 1'b0;
        n_checks++; if (level_o !== 5'd2) begin n_fail++; $display("FAIL rp_top_level got %0d want 2", level_o); end
        n_checks++; if (dout_o !== 8'hB0) begin n_fail++; $display("FAIL rp_top_dout got %h want b0", dout_o); end
        push_i = 1'b1;
        pop_i  = 1'b1;
        din_i  = 8'hC0;
        #1;
        n_checks++; if (dout_o !== 8'hB0) begin n_fail++; $display("FAIL rp_same_cycle_dout got %h want b0", dout_o); end
        tick();
        idle_inputs();
        n_checks++; if (dout_o !== 8'hC0) begin n_fail++; $display("FAIL rp_next_dout got %h want c0", dout_o); end
        n_checks++; if (level_o !== 5'd2) begin n_fail++; $display("FAIL rp_level got %0d want 2", level_o); end
        n_checks++; if (maxLevel_o !== 5'd2) begin n_fail++; $display("FAIL rp_maxLevel got %0d want 2", maxLevel_o); end
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        n_checks++; if (dout_o !== 8'hA0) begin n_fail++; $display("FAIL rp_below_dout got %h want a0", dout_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_i = 1'b1;
            din_i  = 8'h60 + 8'(i);
            tick();
        end
        push_i = 1'b0;
        n_checks++; if (level_o !== 5'd4) begin n_fail++; $display("FAIL ar_pre_level got %0d want 4", level_o); end
        #3;
        rst_i = 1'b1;
        #1;
        n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL ar_level got %0d want 0", level_o); end
        n_checks++; if (isEmpty_o !== 1'b1) begin n_fail++; $display("FAIL ar_isEmpty got %b want 1", isEmpty_o); end
        n_checks++; if (dout_o !== 8'h00) begin n_fail++; $display("FAIL ar_dout got %h want 00", dout_o); end
        n_checks++; if (maxLevel_o !== 5'd0) begin n_fail++; $display("FAIL ar_maxLevel got %0d want 0", maxLevel_o); end
        #2;
        rst_i = 1'b0;
        tick();
        n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL ar_after_level got %0d want 0", level_o); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
